// File: rtl/pipe_cpa_adder_pkg.sv
// Shared types and helpers for the pipelined carry-propagate adder.
// Holds the stage payload layout, inversion-mode encodings and the stage-count helper.
package pipe_cpa_adder_pkg;

    // Payload vectors are sized for the widest supported adder; narrower instances leave the top bits at zero.
    localparam int CPA_MAX_WIDTH = 128;

    typedef enum logic [1:0] {
        INV_NONE = 2'b00,
        INV_A    = 2'b01,
        INV_B    = 2'b10,
        INV_AB   = 2'b11
    } inv_mode_e;

    typedef struct packed {
        logic                     valid;
        logic                     carry;
        logic [CPA_MAX_WIDTH-1:0] a_rem;
        logic [CPA_MAX_WIDTH-1:0] b_rem;
        logic [CPA_MAX_WIDTH-1:0] sum;
    } cpa_stage_t;

    function automatic int cpa_stages(input int width, input int seg);
        return width / seg;
    endfunction

endpackage

// File: rtl/pipe_cpa_adder_if.sv
// Handshake bus of the pipelined adder: operand input channel and result output channel.
interface pipe_cpa_adder_if #(
    parameter int WIDTH = 32
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic [1:0]       in_inv;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_inv, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_inv, out_ready,
        output in_ready, out_valid, out_sum, out_cout
    );

endinterface

// File: rtl/pipe_cpa_stage.sv
// One SEG-bit slice of the carry chain: adds its segment plus the incoming carry and
// registers the result behind an elastic valid/ready handshake.
module pipe_cpa_stage
    import pipe_cpa_adder_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter int               SEG     = 8,
    parameter int               STAGE   = 0,
    parameter logic [WIDTH-1:0] RST_SUM = '0
) (
    input  logic       clk,
    input  logic       rst,
    input  cpa_stage_t up_data,
    output logic       up_ready,
    output cpa_stage_t down_data,
    input  logic       down_ready
);

    localparam int LSB = STAGE * SEG;

    cpa_stage_t   q;
    cpa_stage_t   nxt;
    logic [SEG:0] seg_sum;

    assign seg_sum = {1'b0, up_data.a_rem[LSB +: SEG]}
                   + {1'b0, up_data.b_rem[LSB +: SEG]}
                   + {{SEG{1'b0}}, up_data.carry};

    always_comb begin
        nxt                = up_data;
        nxt.sum[LSB +: SEG] = seg_sum[SEG-1:0];
        nxt.carry          = seg_sum[SEG];
    end

    // The slot may be refilled when it is empty or its content is leaving this cycle.
    assign up_ready = !q.valid || down_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            q                  <= '0;
            q.sum[WIDTH-1:0]   <= RST_SUM;
        end else if (up_ready) begin
            if (up_data.valid) begin
                q <= nxt;
            end else begin
                q.valid <= 1'b0;
            end
        end
    end

    assign down_data = q;

endmodule

// File: rtl/pipe_cpa_adder.sv
// Pipelined carry-propagate adder: normalises optionally inverted operands and ripples
// the carry through STAGES registered SEG-bit slices.
module pipe_cpa_adder
    import pipe_cpa_adder_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter int               SEG     = 8,
    parameter logic [WIDTH-1:0] RST_SUM = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_cpa_adder_if.slave      bus
);

    localparam int STAGES = cpa_stages(WIDTH, SEG);

    if (SEG < 1 || (WIDTH % SEG) != 0) begin : g_bad_seg
        $error("pipe_cpa_adder: WIDTH must be a non-zero multiple of SEG");
    end
    if (STAGES < 1 || WIDTH > CPA_MAX_WIDTH) begin : g_bad_width
        $error("pipe_cpa_adder: WIDTH out of range");
    end

    cpa_stage_t       head;
    cpa_stage_t       link  [STAGES+1];
    logic             ready [STAGES+1];
    logic [WIDTH-1:0] a_norm;
    logic [WIDTH-1:0] b_norm;

    assign a_norm = bus.in_a ^ {WIDTH{bus.in_inv[0]}};
    assign b_norm = bus.in_b ^ {WIDTH{bus.in_inv[1]}};

    always_comb begin
        head                   = '0;
        head.valid             = bus.in_valid && !rst;
        head.carry             = bus.in_cin;
        head.a_rem[WIDTH-1:0]  = a_norm;
        head.b_rem[WIDTH-1:0]  = b_norm;
    end

    assign link[0]       = head;
    assign ready[STAGES] = bus.out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipe_cpa_stage #(
            .WIDTH   (WIDTH),
            .SEG     (SEG),
            .STAGE   (k),
            .RST_SUM (RST_SUM)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .up_data    (link[k]),
            .up_ready   (ready[k]),
            .down_data  (link[k+1]),
            .down_ready (ready[k+1])
        );
    end

    // Stage 0 would report ready while being cleared, so hold off the producer during reset.
    assign bus.in_ready  = ready[0] && !rst;
    assign bus.out_valid = link[STAGES].valid;
    assign bus.out_sum   = link[STAGES].sum[WIDTH-1:0];
    assign bus.out_cout  = link[STAGES].carry;

endmodule

// File: tb/tb_pipe_cpa_adder.sv
// Self-checking bench for pipe_cpa_adder: directed steps with a result scoreboard.
module tb_pipe_cpa_adder;
    import pipe_cpa_adder_pkg::*;

    localparam int WIDTH  = 32;
    localparam int SEG    = 8;
    localparam int STAGES = 4;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pipe_cpa_adder_if #(.WIDTH(WIDTH)) bus ();

    pipe_cpa_adder #(
        .WIDTH   (WIDTH),
        .SEG     (SEG),
        .RST_SUM ('0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    exp_t pop_e;
    logic [WIDTH:0] push_r;
    int checks       = 0;
    int errors       = 0;
    int cyc          = 0;
    int pop_count    = 0;
    int last_pop_cyc = 0;
    int accept_cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [WIDTH:0] refAdd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic cin, input logic [1:0] inv);
        logic [WIDTH-1:0] aa;
        logic [WIDTH-1:0] bb;
        if (inv[0]) aa = ~a; else aa = a;
        if (inv[1]) bb = ~b; else bb = b;
        return {1'b0, aa} + {1'b0, bb} + {{WIDTH{1'b0}}, cin};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Scoreboard: record each accept, compare each drained result in order.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                checkOutput("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    pop_e = sb.pop_front();
                    checkOutput("sb_sum", 64'(bus.out_sum), 64'(pop_e.sum));
                    checkOutput("sb_cout", 64'(bus.out_cout), 64'(pop_e.cout));
                    pop_count++;
                    last_pop_cyc = cyc;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                push_r = refAdd(bus.in_a, bus.in_b, bus.in_cin, bus.in_inv);
                sb.push_back('{sum: push_r[WIDTH-1:0], cout: push_r[WIDTH]});
            end
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the operands.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic [1:0] inv);
        logic accepted;
        accepted     = 1'b0;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        bus.in_inv   = inv;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 50 && !accepted; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                accepted   = 1'b1;
                accept_cyc = cyc;
            end else begin
                nextCycle();
            end
        end
        checkOutput("accept_in_time", 64'(accepted), 64'd1);
        nextCycle();
        bus.in_valid = 1'b0;
    endtask

    task automatic waitOutput();
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (bus.out_valid) break;
        end
        checkOutput("out_valid_in_time", 64'(bus.out_valid), 64'd1);
    endtask

    task automatic waitPops(input int target);
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            #1;
            if (pop_count >= target) break;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int pc0;
        int stream_start;
        int stall_accepts;
        int stray;
        logic [WIDTH-1:0] hold_sum;
        logic             hold_cout;

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.in_inv    = INV_NONE;
        bus.out_ready = 1'b1;
        rst           = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd0);
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_out_sum", 64'(bus.out_sum), 64'd0);
        checkOutput("rst_out_cout", 64'(bus.out_cout), 64'd0);
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        nextCycle();

        $display("[TB] directed carry cases");
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, INV_NONE);
        waitOutput();
        checkOutput("latency", 64'(cyc - accept_cyc), 64'(STAGES));
        checkOutput("wrap_sum", 64'(bus.out_sum), 64'h0000_0000);
        checkOutput("wrap_cout", 64'(bus.out_cout), 64'd1);
        nextCycle();

        applyStimulus(32'h0000_0000, 32'h0000_0000, 1'b0, INV_AB);
        waitOutput();
        checkOutput("inv_ab_sum", 64'(bus.out_sum), 64'hFFFF_FFFE);
        checkOutput("inv_ab_cout", 64'(bus.out_cout), 64'd1);
        nextCycle();

        applyStimulus(32'h0000_0000, 32'h0000_0000, 1'b1, INV_A);
        waitOutput();
        checkOutput("inv_a_sum", 64'(bus.out_sum), 64'h0000_0000);
        checkOutput("inv_a_cout", 64'(bus.out_cout), 64'd1);
        nextCycle();

        applyStimulus(32'h00FF_FFFF, 32'h0000_0001, 1'b0, INV_NONE);
        waitOutput();
        checkOutput("seg_carry_sum", 64'(bus.out_sum), 64'h0100_0000);
        checkOutput("seg_carry_cout", 64'(bus.out_cout), 64'd0);
        nextCycle();

        $display("[TB] back-to-back stream");
        pc0 = pop_count;
        stream_start = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            if (i == 0) stream_start = accept_cyc;
        end
        waitPops(pc0 + 8);
        checkOutput("stream_count", 64'(pop_count - pc0), 64'd8);
        checkOutput("stream_span", 64'(last_pop_cyc - stream_start), 64'(STAGES + 7));
        nextCycle();

        $display("[TB] output stall");
        pc0           = pop_count;
        stall_accepts = 0;
        hold_sum      = '0;
        hold_cout     = 1'b0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            bus.in_a     = 32'h1111_1111 * (stall_accepts + 1);
            bus.in_b     = 32'h0F0F_0F0F;
            bus.in_cin   = stall_accepts[0];
            bus.in_inv   = stall_accepts[1:0];
            bus.in_valid = 1'b1;
            @(negedge clk);
            if (c == 4) begin
                hold_sum  = bus.out_sum;
                hold_cout = bus.out_cout;
                checkOutput("stall_full_valid", 64'(bus.out_valid), 64'd1);
                checkOutput("stall_full_in_ready", 64'(bus.in_ready), 64'd0);
            end
            if (c == 5) begin
                checkOutput("stall_hold_sum", 64'(bus.out_sum), 64'(hold_sum));
                checkOutput("stall_hold_cout", 64'(bus.out_cout), 64'(hold_cout));
                checkOutput("stall_hold_in_ready", 64'(bus.in_ready), 64'd0);
            end
            if (bus.in_ready) stall_accepts++;
            nextCycle();
        end
        checkOutput("stall_accepts", 64'(stall_accepts), 64'd4);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        waitPops(pc0 + 4);
        checkOutput("stall_drain_count", 64'(pop_count - pc0), 64'd4);
        nextCycle();

        $display("[TB] reset with results in flight");
        pc0 = pop_count;
        applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0, INV_NONE);
        applyStimulus(32'hDEAD_BEEF, 32'h0000_0001, 1'b1, INV_B);
        applyStimulus(32'hCAFE_F00D, 32'h8000_0000, 1'b0, INV_AB);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
        nextCycle();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("after_rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("after_rst_in_ready", 64'(bus.in_ready), 64'd1);
        stray = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (bus.out_valid) stray++;
        end
        checkOutput("flushed_results", 64'(stray), 64'd0);
        checkOutput("flushed_pop_count", 64'(pop_count - pc0), 64'd0);
        checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_cpa_adder.md
Name: pipe_cpa_adder

Overview:
- Parametrised, pipelined carry-propagate adder. Converts the final carry-save pair from the Booth-4/Wallace compressor tree into a binary result.
- Generalises the inverted-input adder cell: each operand can arrive true or inverted (selected per transaction), at arbitrary width.
- Splits the carry chain into SEG-bit segments, one segment per pipeline stage.
- Uses a valid/ready handshake so it can sit between the compressor tree and downstream accumulation/output logic.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SEG, 8, bits added per pipeline stage. WIDTH must be a multiple of SEG. STAGES = WIDTH/SEG, and STAGES ≥ 1.
- RST_SUM, 0, value driven on out_sum while reset or idle-cleared.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept input this cycle.
- in_a  in  WIDTH  operand A (true or inverted form, per in_inv[0]).
- in_b  in  WIDTH  operand B (true or inverted form, per in_inv[1]).
- in_cin  in  1  carry-in.
- in_inv  in  2  bit0 = 1: in_a carries ~A; bit1 = 1: in_b carries ~B.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  WIDTH  (A + B + cin) mod 2^WIDTH.
- out_cout  out  1  carry out of bit WIDTH-1.

Behaviour:
- **Clock and reset.** One clock. Reset is synchronous and active-high: rst sampled high at a rising edge of clk clears state.
- **Reset values.**
  - out_valid = 0, out_sum = RST_SUM, out_cout = 0.
  - All stage valid flags = 0.
  - in_ready = 0 while rst is high. Any handshake in a cycle with rst high is discarded.
  - From the first cycle with rst low: in_ready = 1.
- **Input handshake.** Accept occurs when in_valid && in_ready at a clock edge.
  - At accept, operands are normalised: A = in_inv[0] ? ~in_a : in_a, and B likewise with in_inv[1].
  - Normalisation is an XOR with the replicated mode bit; no separate inverter path.
- **Stage k (0..STAGES-1).**
  - Adds bits [k*SEG +: SEG] of A and B plus the carry from stage k-1 (in_cin for k = 0).
  - Registers the sum segment and carry-out.
  - Forwards the not-yet-added upper bits of A and B plus the completed lower sum bits.
  - The final stage drives out_sum and out_cout directly from its registers.
- **Latency.** STAGES cycles from accept to out_valid, with no stall. Throughput is one result per cycle.
- **Flow control.** Per-stage elastic handshake: ready_k = !valid_k || ready_{k+1}, with ready_STAGES = out_ready. in_ready = ready_0 (gated by !rst).
  - Bubbles collapse: a stage advances whenever its successor is empty or draining.
  - When out_valid && !out_ready, out_sum and out_cout hold stable.
  - When all STAGES registers are valid and stalled, in_ready = 0.
- **Ordering.** Results leave strictly in acceptance order. No loss, no duplication.
- **Simultaneous accept and drain** with a full pipeline and out_ready = 1: in_ready = 1, occupancy unchanged.
- **Wrap-around.** The sum is modulo 2^WIDTH; overflow is reported only on out_cout.
- **Reset mid-operation.** All in-flight results are dropped. out_valid = 0 on the cycle after the reset edge.
- **Parameter check.** WIDTH % SEG != 0 must fail at elaboration.

Decomposition:
- Shared package contents:
  - STAGES derivation function.
  - In_inv mode encodings: INV_NONE = 2'b00, INV_A = 2'b01, INV_B = 2'b10, INV_AB = 2'b11.
  - Stage payload struct: remaining A/B, partial sum, carry, valid.
- Natural sub-module: pipe_cpa_stage, a single SEG-bit adder-plus-register slice with valid/ready. Instantiate it STAGES times in a generate loop.
- Top level holds only input normalisation and the handshake chain wiring.

Test Plan (WIDTH = 32, SEG = 8, STAGES = 4):
- in_a = 0xFFFFFFFF, in_b = 0x00000001, cin = 0, inv = 00 -> after 4 cycles out_sum = 0x00000000, out_cout = 1.
- in_a = 0x00000000, in_b = 0x00000000, cin = 0, inv = 11 (A = B = 0xFFFFFFFF) -> out_sum = 0xFFFFFFFE, out_cout = 1. Same operands with inv = 01, cin = 1 -> out_sum = 0x00000000, out_cout = 1.
- in_a = 0x00FFFFFF, in_b = 0x00000001, inv = 00 -> out_sum = 0x01000000, out_cout = 0 (carry crosses segments 0-2).
- Stream 8 random transactions back-to-back with out_ready = 1 -> 8 consecutive out_valid cycles starting 4 cycles after the first accept. Results in order and matching a reference model.
- Stream continuously while holding out_ready = 0 for 6 cycles -> in_ready drops once 4 results are held. out_sum stays stable. After release, all results arrive in order with none lost or duplicated.
- Accept 3 transactions, assert rst for 1 cycle -> out_valid = 0 from the next cycle and none of the 3 appear. in_ready = 0 during rst and 1 the following cycle.
